display_scan: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits, placed directly upstream of the binary-to-7-segment decoder. It latches a packed multi-nibble value, walks through the digits at a programmable refresh rate, and presents one 4-bit nibble at a time together with an active-low digit enable. The decoder turns the nibble into active-low segments. Optional leading-zero blanking and a one-cycle guard between digits suppress ghosting.

---
 rtl/display_pkg.sv | 11 +
 rtl/tick_gen.sv | 20 ++
 rtl/display_scan.sv | 76 +++++++
 tb/tb_display_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan driver and the decoder top level.
package display_pkg;
    localparam int DIGITS_DEF      = 4;
    localparam int REFRESH_DIV_DEF = 50000;
    localparam int DIGITS_MAX      = 8;

    // Wide enough for the largest bank; slice down to DIGITS at the use site.
    localparam logic [DIGITS_MAX-1:0] DIGIT_OFF = '1;

    typedef enum logic {GUARD, SCAN} state_t;
endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_cnt;

    assign tick = (div_cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: rtl/display_scan.sv
// Time-multiplexed digit scanner feeding a 7-segment decoder; one guard
// cycle with all digits dark separates consecutive digit slots.
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            digit_nibble,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_done
);
    localparam int IW = $clog2(DIGITS);

    state_t              state, state_nx;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow;
    logic                tick;
    logic                idx_last;
    logic                blanked;
    logic [3:0]          nib_nx;
    logic [DIGITS-1:0]   en_nx;

    tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign idx_last = (idx == IW'(DIGITS - 1));

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        blanked = blank_lz && (idx != '0);
        for (int i = 0; i < DIGITS; i++)
            if (i >= int'(idx) && shadow[4*i +: 4] != 4'd0) blanked = 1'b0;
    end

    always_comb begin
        state_nx = state;
        nib_nx   = digit_nibble;
        en_nx    = DIGIT_OFF[DIGITS-1:0];
        case (state)
            GUARD: state_nx = SCAN;
            SCAN: begin
                nib_nx = shadow[4*idx +: 4];
                if (!blanked) en_nx = ~(DIGITS'(1) << idx);
                if (tick) state_nx = GUARD;
            end
            default: state_nx = GUARD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= GUARD;
            idx          <= '0;
            shadow       <= '0;
            frame_done   <= 1'b0;
            digit_nibble <= 4'd0;
            digit_en_n   <= DIGIT_OFF[DIGITS-1:0];
        end else begin
            state        <= state_nx;
            if (load) shadow <= value;
            if (tick) idx <= idx_last ? '0 : idx + 1'b1;
            frame_done   <= tick && idx_last;
            digit_nibble <= nib_nx;
            digit_en_n   <= en_nx;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench: a time-based reference model predicts every output cycle
// for two scanners (slot length 4 and 2) driven by the same stimulus.
module tb_display_scan;
    localparam int DG = 4;

    logic          clk = 1'b0;
    logic          reset, load, blank_lz;
    logic [4*DG-1:0] value;
    logic [3:0]    nib_a, nib_b;
    logic [DG-1:0] en_a, en_b;
    logic          fd_a, fd_b;

    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] en;
        logic       fd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    display_scan #(.DIGITS(DG), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .digit_nibble(nib_a), .digit_en_n(en_a), .frame_done(fd_a));

    display_scan #(.DIGITS(DG), .REFRESH_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .digit_nibble(nib_b), .digit_en_n(en_b), .frame_done(fd_b));

    // j = cycles elapsed since the reset edge; slot position and digit follow
    // directly from j, and outputs lag the internal state by one register.
    function automatic exp_t predict(int div, int j, logic [15:0] sh, logic blz,
                                     logic [3:0] prev_nib);
        exp_t e;
        int   d  = j % div;
        int   ix = (j / div) % DG;
        e.fd = (((j + 1) % (div * DG)) == 0);
        e.en = 4'hF;
        if (d == 0) begin
            e.nib = prev_nib;
        end else begin
            e.nib = sh[4*ix +: 4];
            if (!(blz && ix > 0 && (sh >> (4*ix)) == 16'd0)) e.en[ix] = 1'b0;
        end
        return e;
    endfunction

    initial begin
        logic [15:0] sh;
        logic [3:0]  na, nb;
        int          j;
        exp_t        ea, eb;
        sh = '0; na = '0; nb = '0; j = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                sh = '0; na = '0; nb = '0; j = 0;
                ea = '{nib: 4'h0, en: 4'hF, fd: 1'b0};
                eb = ea;
            end else begin
                ea = predict(4, j, sh, blank_lz, na);
                eb = predict(2, j, sh, blank_lz, nb);
                na = ea.nib;
                nb = eb.nib;
                j++;
                if (load) sh = value;
            end
            qa.push_back(ea);
            qb.push_back(eb);
        end
    end

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_nibble", nib_a, e.nib);
                check("a_en_n",   en_a,  e.en);
                check("a_frame",  {3'b0, fd_a}, {3'b0, e.fd});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_nibble", nib_b, e.nib);
                check("b_en_n",   en_b,  e.en);
                check("b_frame",  {3'b0, fd_b}, {3'b0, e.fd});
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(logic [15:0] v);
        value = v; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0F0F};
        reset = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        // plain scan order
        pulse_load(16'h1A2F);
        cyc(40);
        // leading-zero blanking
        blank_lz = 1'b1;
        pulse_load(16'h0050);
        cyc(36);
        pulse_load(16'h0000);
        cyc(36);
        blank_lz = 1'b0;
        // load during reset is dropped; then load lands on the idx 1->2 tick
        reset = 1'b1; value = 16'h5555; load = 1'b1;
        cyc(1);
        load = 1'b0; reset = 1'b0;
        pulse_load(16'h1234);
        cyc(6);
        pulse_load(16'h9999);
        cyc(20);
        // reset in the middle of a slot
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(24);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(99) == 0);
            load  = ($urandom_range(5) == 0);
            value = 16'($urandom) & masks[$urandom_range(4)];
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
            cyc(1);
        end
        reset = 1'b0; load = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
